// File: rtl/dimm_pkg.sv
// Shared DIMM datapath types: timeline slot layout, burst sizes and latency clamp.
package dimm_pkg;
    localparam int RANK_W_MAX = 2;
    localparam int IDX_W_MAX  = 6;
    localparam int POS_W      = 8;
    localparam int BL8_BEATS  = 8;
    localparam int BC4_BEATS  = 4;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [RANK_W_MAX-1:0] rank;
        logic [IDX_W_MAX-1:0]  idx;
        logic                  last;
    } slot_t;

    // Two cycles is the shortest latency that still leaves room for the read preamble.
    function automatic int clamp_lat(input int lat, input int max_lat);
        if (lat < 2) return 2;
        if (lat > max_lat) return max_lat;
        return lat;
    endfunction
endpackage

// File: rtl/burst_timeline.sv
// Latency timeline: one slot per future data cycle, shifted toward slot 0 every cycle.
// A new burst is inserted only if every slot it needs is still free after the shift.
module burst_timeline
    import dimm_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ins_valid,
    input  logic                  ins_wr,
    input  logic [RANK_W_MAX-1:0] ins_rank,
    input  logic [POS_W-1:0]      ins_lat,
    input  logic [POS_W-1:0]      ins_beats,
    output slot_t                 slot0,
    output slot_t                 slot1,
    output logic                  any_valid,
    output logic                  collision
);
    slot_t slots   [DEPTH];
    slot_t shifted [DEPTH];
    slot_t fill    [DEPTH];
    logic  in_win  [DEPTH];
    logic  hit;

    always_comb begin
        int off;
        off = 0;
        for (int j = 0; j < DEPTH - 1; j++) shifted[j] = slots[j + 1];
        shifted[DEPTH - 1] = '0;
        hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            off       = j - (int'(ins_lat) - 1);
            in_win[j] = (off >= 0) && (off < int'(ins_beats));
            fill[j]   = '0;
            if (in_win[j]) begin
                fill[j].valid = 1'b1;
                fill[j].wr    = ins_wr;
                fill[j].rank  = ins_rank;
                fill[j].idx   = IDX_W_MAX'(off);
                fill[j].last  = (off == int'(ins_beats) - 1);
                if (shifted[j].valid) hit = 1'b1;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int j = 0; j < DEPTH; j++) any_valid = any_valid | slots[j].valid;
    end

    assign collision = ins_valid & hit;
    assign slot0     = slots[0];
    assign slot1     = slots[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) slots[j] <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++)
                slots[j] <= (ins_valid && !hit && in_win[j]) ? fill[j] : shifted[j];
        end
    end
endmodule

// File: rtl/rank_burst_sched.sv
// Multi-rank data-burst scheduler: places each RD/WR burst CL/CWL cycles out on a
// timeline and drives registered per-beat DQ/DQS enables, beat index and rank.
module rank_burst_sched
    import dimm_pkg::*;
#(
    parameter int RANKS    = 2,
    parameter int BL       = BL8_BEATS,
    parameter int MAXLAT   = 24,
    parameter int LATWIDTH = 5,
    parameter int RWIDTH   = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic                  cmd_wr,
    input  logic                  cmd_bc4,
    input  logic [RWIDTH-1:0]     cmd_rank,
    input  logic [LATWIDTH-1:0]   cl,
    input  logic [LATWIDTH-1:0]   cwl,
    output logic                  dq_oe,
    output logic                  dq_ie,
    output logic                  dqs_oe,
    output logic [$clog2(BL)-1:0] beat_idx,
    output logic [RWIDTH-1:0]     beat_rank,
    output logic                  beat_last,
    output logic                  busy,
    output logic                  err_collision,
    output logic [7:0]            coll_count
);
    localparam int DEPTH = MAXLAT + BL;
    localparam int IDXW  = $clog2(BL);
    localparam int BC4_N = (BL == BL8_BEATS) ? BC4_BEATS : BL / 2;

    logic [POS_W-1:0] lat_sel;
    logic [POS_W-1:0] beats_sel;
    slot_t            slot0;
    slot_t            slot1;
    logic             any_valid;
    logic             collision;
    logic             coll_q;
    logic             rd0;
    logic             rd1_first;
    logic             unused_hi;

    always_comb begin
        lat_sel   = POS_W'(clamp_lat(int'(cmd_wr ? cwl : cl), MAXLAT));
        beats_sel = cmd_bc4 ? POS_W'(BC4_N) : POS_W'(BL);
    end

    burst_timeline #(.DEPTH(DEPTH)) u_timeline (
        .clk       (clk),
        .reset     (reset),
        .ins_valid (cmd_valid),
        .ins_wr    (cmd_wr),
        .ins_rank  (RANK_W_MAX'(cmd_rank)),
        .ins_lat   (lat_sel),
        .ins_beats (beats_sel),
        .slot0     (slot0),
        .slot1     (slot1),
        .any_valid (any_valid),
        .collision (collision)
    );

    assign rd0       = slot0.valid & ~slot0.wr;
    assign rd1_first = slot1.valid & ~slot1.wr & (slot1.idx == '0);
    assign unused_hi = ^{slot0, slot1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq_oe         <= 1'b0;
            dq_ie         <= 1'b0;
            dqs_oe        <= 1'b0;
            beat_idx      <= '0;
            beat_rank     <= '0;
            beat_last     <= 1'b0;
            busy          <= 1'b0;
            coll_q        <= 1'b0;
            err_collision <= 1'b0;
            coll_count    <= 8'd0;
        end else begin
            dq_oe     <= rd0;
            dq_ie     <= slot0.valid & slot0.wr;
            // Read DQS opens one cycle early unless a read beat already holds it open.
            dqs_oe    <= rd0 | (rd1_first & ~rd0);
            beat_idx  <= slot0.valid ? slot0.idx[IDXW-1:0] : '0;
            beat_rank <= slot0.valid ? slot0.rank[RWIDTH-1:0] : '0;
            beat_last <= slot0.valid & slot0.last;
            busy      <= any_valid;
            coll_q        <= collision;
            err_collision <= coll_q;
            if (coll_q && coll_count != 8'hFF) coll_count <= coll_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_rank_burst_sched.sv
// Randomized scoreboard bench for rank_burst_sched against a per-cycle occupancy model.
module tb_rank_burst_sched;
    import dimm_pkg::*;

    localparam int RANKS    = 2;
    localparam int BL       = 8;
    localparam int MAXLAT   = 24;
    localparam int LATWIDTH = 5;
    localparam int RWIDTH   = 1;
    localparam int IDXW     = 3;
    localparam int NCYC     = 8192;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_wr;
    logic                cmd_bc4;
    logic [RWIDTH-1:0]   cmd_rank;
    logic [LATWIDTH-1:0] cl;
    logic [LATWIDTH-1:0] cwl;
    logic                dq_oe;
    logic                dq_ie;
    logic                dqs_oe;
    logic [IDXW-1:0]     beat_idx;
    logic [RWIDTH-1:0]   beat_rank;
    logic                beat_last;
    logic                busy;
    logic                err_collision;
    logic [7:0]          coll_count;

    rank_burst_sched #(
        .RANKS(RANKS), .BL(BL), .MAXLAT(MAXLAT), .LATWIDTH(LATWIDTH), .RWIDTH(RWIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_bc4(cmd_bc4), .cmd_rank(cmd_rank),
        .cl(cl), .cwl(cwl),
        .dq_oe(dq_oe), .dq_ie(dq_ie), .dqs_oe(dqs_oe),
        .beat_idx(beat_idx), .beat_rank(beat_rank), .beat_last(beat_last),
        .busy(busy), .err_collision(err_collision), .coll_count(coll_count)
    );

    typedef struct {
        int cyc;
        bit wr;
        int idx;
        int rank;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_valid [NCYC];
    bit    m_wr    [NCYC];
    int    m_idx   [NCYC];
    bit    m_err   [NCYC];
    bit    m_busy  [NCYC];
    int    m_cnt    = 0;
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Called at a falling edge: the command is sampled at the next rising edge.
    task automatic issue(input bit wr, input bit bc4, input int rank);
        int    t, lat, n, pos;
        bit    clash;
        beat_t b;
        t   = cyc + 1;
        lat = wr ? int'(cwl) : int'(cl);
        if (lat < 2) lat = 2;
        if (lat > MAXLAT) lat = MAXLAT;
        n     = bc4 ? BL / 2 : BL;
        clash = 1'b0;
        for (int k = 0; k < n; k++) if (m_valid[t + lat + k]) clash = 1'b1;
        if (clash) begin
            m_err[t + 1] = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                m_valid[t + lat + k] = 1'b1;
                m_wr[t + lat + k]    = wr;
                m_idx[t + lat + k]   = k;
                b.cyc  = t + lat + k;
                b.wr   = wr;
                b.idx  = k;
                b.rank = rank;
                b.last = (k == n - 1);
                pos = exp_q.size();
                while (pos > 0 && exp_q[pos - 1].cyc > b.cyc) pos--;
                exp_q.insert(pos, b);
            end
            for (int c = t + 1; c < t + lat + n; c++) m_busy[c] = 1'b1;
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_bc4   = bc4;
        cmd_rank  = rank[RWIDTH-1:0];
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush_model();
        for (int c = cyc; c < NCYC; c++) begin
            m_valid[c] = 1'b0;
            m_wr[c]    = 1'b0;
            m_idx[c]   = 0;
            m_err[c]   = 1'b0;
            m_busy[c]  = 1'b0;
        end
        exp_q.delete();
        m_cnt = 0;
    endtask

    // Entered just after a rising edge; asserts reset in the middle of the cycle.
    task automatic reset_mid_cycle();
        #3 reset = 1'b1;
        #1;
        check("rst_outputs", int'({dq_oe, dq_ie, dqs_oe, beat_idx, beat_rank, beat_last,
                                   busy, err_collision}), 0);
        check("rst_coll_count", int'(coll_count), 0);
        flush_model();
        idle(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        int    c;
        bit    exp_beat, act_beat, rd_c, rd_n;
        beat_t b;
        c = cyc;
        while (exp_q.size() > 0 && exp_q[0].cyc < c) void'(exp_q.pop_front());
        exp_beat = (exp_q.size() > 0 && exp_q[0].cyc == c);
        act_beat = dq_oe | dq_ie;
        check("beat_present", int'(act_beat), int'(exp_beat));
        if (exp_beat) begin
            b = exp_q.pop_front();
            check("dq_ie", int'(dq_ie), int'(b.wr));
            check("dq_oe", int'(dq_oe), int'(!b.wr));
            check("beat_idx", int'(beat_idx), b.idx);
            check("beat_rank", int'(beat_rank), b.rank);
            check("beat_last", int'(beat_last), int'(b.last));
        end else begin
            check("idle_fields", int'({beat_idx, beat_rank, beat_last}), 0);
        end
        rd_c = m_valid[c] && !m_wr[c];
        rd_n = m_valid[c + 1] && !m_wr[c + 1] && (m_idx[c + 1] == 0);
        check("dqs_oe", int'(dqs_oe), int'(rd_c || (rd_n && !rd_c)));
        if (m_err[c] && m_cnt < 255) m_cnt++;
        check("err_collision", int'(err_collision), int'(m_err[c]));
        check("coll_count", int'(coll_count), m_cnt);
        check("busy", int'(busy), int'(m_busy[c]));
    end

    initial begin
        int target;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_bc4   = 1'b0;
        cmd_rank  = '0;
        cl        = 5'd11;
        cwl       = 5'd9;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        idle(3);
        reset = 1'b0;

        idle(5);
        issue(1'b0, 1'b0, 1);
        idle(25);
        issue(1'b1, 1'b1, 0);
        idle(20);
        issue(1'b0, 1'b0, 0);
        idle(7);
        issue(1'b0, 1'b0, 1);
        idle(30);
        issue(1'b0, 1'b0, 0);
        idle(3);
        issue(1'b0, 1'b0, 0);
        idle(30);
        cl = 5'd1;
        issue(1'b0, 1'b0, 1);
        idle(15);
        cl = 5'd31;
        issue(1'b0, 1'b1, 0);
        idle(40);
        cwl = 5'd0;
        issue(1'b1, 1'b0, 1);
        idle(12);

        cl = 5'd11;
        issue(1'b0, 1'b0, 1);
        target = cyc + 11 + 2;
        while (cyc < target - 1) @(negedge clk);
        @(posedge clk);
        reset_mid_cycle();
        idle(3);
        issue(1'b0, 1'b0, 1);
        idle(30);

        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) begin
                cl  = LATWIDTH'($urandom_range(0, 31));
                cwl = LATWIDTH'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 4) == 0)
                issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, RANKS - 1));
            else
                idle(1);
        end

        // Dense stream drives the collision counter into saturation.
        cl  = 5'd10;
        cwl = 5'd10;
        for (int i = 0; i < 600; i++)
            issue(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, RANKS - 1));
        issue(1'b0, BC4_BEATS == BL / 2, 0);
        idle(60);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
